// File: rtl/gate_pkg.sv
// Shared definitions for the pipelined logic gate.
//   MODE_WIDTH       width of the function-select field
//   MODE_AND..XNOR   function encodings; 6 and 7 are reserved
//   mode_is_reserved true for any encoding outside AND..XNOR
package gate_pkg;

  localparam int MODE_WIDTH = 3;

  localparam logic [MODE_WIDTH-1:0] MODE_AND  = 3'd0;
  localparam logic [MODE_WIDTH-1:0] MODE_NAND = 3'd1;
  localparam logic [MODE_WIDTH-1:0] MODE_OR   = 3'd2;
  localparam logic [MODE_WIDTH-1:0] MODE_NOR  = 3'd3;
  localparam logic [MODE_WIDTH-1:0] MODE_XOR  = 3'd4;
  localparam logic [MODE_WIDTH-1:0] MODE_XNOR = 3'd5;

  function automatic logic mode_is_reserved(input logic [MODE_WIDTH-1:0] mode);
    return (mode > MODE_XNOR);
  endfunction

endpackage

// File: rtl/pipelined_logic_gate_if.sv
// Handshake bundle for the pipelined logic gate.
//   In_Valid/In_Ready   upstream handshake for Inputs + Mode
//   Inputs              operand i in bits [i*BitWidth +: BitWidth]
//   Mode                function select
//   Out_Valid/Out_Ready downstream handshake for Result
//   Result              reduction result
//   Mode_Error          sticky reserved-mode flag
// master: the side feeding operands and consuming results; slave: the gate.
interface pipelined_logic_gate_if #(
  parameter int NrOfInputs = 2,
  parameter int BitWidth   = 1
);
  import gate_pkg::*;

  logic                             In_Valid;
  logic                             In_Ready;
  logic [NrOfInputs*BitWidth-1:0]   Inputs;
  logic [MODE_WIDTH-1:0]            Mode;
  logic                             Out_Valid;
  logic                             Out_Ready;
  logic [BitWidth-1:0]              Result;
  logic                             Mode_Error;

  modport master (
    output In_Valid, Inputs, Mode, Out_Ready,
    input  In_Ready, Out_Valid, Result, Mode_Error
  );

  modport slave (
    input  In_Valid, Inputs, Mode, Out_Ready,
    output In_Ready, Out_Valid, Result, Mode_Error
  );

endinterface

// File: rtl/gate_reduce.sv
// Combinational bitwise reduction of NrOfInputs operands of BitWidth bits.
//   operands  flattened operands, operand i at [i*BitWidth +: BitWidth]
//   mode      function select (AND/NAND/OR/NOR/XOR/XNOR)
//   result    reduction result, zero for reserved modes
//   reserved  high when mode is a reserved encoding
module gate_reduce
  import gate_pkg::*;
#(
  parameter int NrOfInputs = 2,
  parameter int BitWidth   = 1
) (
  input  logic [NrOfInputs*BitWidth-1:0] operands,
  input  logic [MODE_WIDTH-1:0]          mode,
  output logic [BitWidth-1:0]            result,
  output logic                           reserved
);

  logic [BitWidth-1:0] and_r;
  logic [BitWidth-1:0] or_r;
  logic [BitWidth-1:0] xor_r;

  always_comb begin
    and_r = '1;
    or_r  = '0;
    xor_r = '0;
    for (int i = 0; i < NrOfInputs; i++) begin
      and_r = and_r & operands[i*BitWidth +: BitWidth];
      or_r  = or_r  | operands[i*BitWidth +: BitWidth];
      xor_r = xor_r ^ operands[i*BitWidth +: BitWidth];
    end
  end

  always_comb begin
    result   = '0;
    reserved = 1'b0;
    case (mode)
      MODE_AND:  result = and_r;
      MODE_NAND: result = ~and_r;
      MODE_OR:   result = or_r;
      MODE_NOR:  result = ~or_r;
      MODE_XOR:  result = xor_r;
      MODE_XNOR: result = ~xor_r;
      default:   reserved = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipelined_logic_gate.sv
// Two-stage pipelined N-input logic gate with per-input bubbles and
// run-time function select, valid/ready flow control on both sides.
//   Clock  rising-edge clock
//   Reset  synchronous, active-high; discards in-flight items
//   bus    slave side of pipelined_logic_gate_if (handshakes, operands,
//          Mode, Result, Mode_Error)
module pipelined_logic_gate
  import gate_pkg::*;
#(
  parameter int                    NrOfInputs  = 2,
  parameter int                    BitWidth    = 1,
  parameter logic [NrOfInputs-1:0] BubblesMask = '0
) (
  input  logic                   Clock,
  input  logic                   Reset,
  pipelined_logic_gate_if.slave  bus
);

  localparam int OpW = NrOfInputs * BitWidth;

  logic                  s2_free;
  logic                  s1_free;
  logic                  accept;
  logic [OpW-1:0]        bubbled;

  logic                  vld_p1;
  logic [OpW-1:0]        ops_p1;
  logic [MODE_WIDTH-1:0] mode_p1;

  logic [BitWidth-1:0]   red;
  logic                  rsvd;
  logic [BitWidth-1:0]   res_d;

  logic                  vld_p2;
  logic [BitWidth-1:0]   res_p2;
  logic                  mode_err;

  // Ready chain is purely combinational so a full pipe can drain and
  // refill in the same cycle.
  assign s2_free      = !vld_p2 || bus.Out_Ready;
  assign s1_free      = !vld_p1 || s2_free;
  assign bus.In_Ready = s1_free && !Reset;
  assign accept       = bus.In_Valid && bus.In_Ready;

  always_comb begin
    bubbled = bus.Inputs;
    for (int i = 0; i < NrOfInputs; i++) begin
      if (BubblesMask[i]) begin
        bubbled[i*BitWidth +: BitWidth] = ~bus.Inputs[i*BitWidth +: BitWidth];
      end
    end
  end

  // ---- Stage 1: bubbled operands and Mode ----
  always_ff @(posedge Clock) begin
    if (Reset) begin
      vld_p1 <= 1'b0;
    end else if (s1_free) begin
      vld_p1 <= accept;
    end
  end

  always_ff @(posedge Clock) begin
    if (accept) begin
      ops_p1  <= bubbled;
      mode_p1 <= bus.Mode;
    end
  end

  // Mode_Error flags at acceptance, not when the item reaches the output.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      mode_err <= 1'b0;
    end else if (accept && mode_is_reserved(bus.Mode)) begin
      mode_err <= 1'b1;
    end
  end

  gate_reduce #(
    .NrOfInputs (NrOfInputs),
    .BitWidth   (BitWidth)
  ) u_reduce (
    .operands (ops_p1),
    .mode     (mode_p1),
    .result   (red),
    .reserved (rsvd)
  );

  assign res_d = rsvd ? '0 : red;

  // ---- Stage 2: registered Result, held while stalled ----
  always_ff @(posedge Clock) begin
    if (Reset) begin
      vld_p2 <= 1'b0;
      res_p2 <= '0;
    end else if (s2_free) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        res_p2 <= res_d;
      end
    end
  end

  assign bus.Out_Valid  = vld_p2;
  assign bus.Result     = res_p2;
  assign bus.Mode_Error = mode_err;

endmodule

// File: tb/tb_pipelined_logic_gate.sv
// Directed, table-driven bench for pipelined_logic_gate.
// dut_a: 3 inputs x 4 bits, no bubbles. dut_b: 2 inputs x 8 bits, operand 1 bubbled.
module tb_pipelined_logic_gate;
  import gate_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipelined_logic_gate_if #(.NrOfInputs(3), .BitWidth(4)) if_a ();
  pipelined_logic_gate_if #(.NrOfInputs(2), .BitWidth(8)) if_b ();

  pipelined_logic_gate #(
    .NrOfInputs(3), .BitWidth(4), .BubblesMask(3'b000)
  ) dut_a (
    .Clock(clk), .Reset(rst), .bus(if_a)
  );

  pipelined_logic_gate #(
    .NrOfInputs(2), .BitWidth(8), .BubblesMask(2'b10)
  ) dut_b (
    .Clock(clk), .Reset(rst), .bus(if_b)
  );

  typedef struct {
    logic [15:0] ins;
    logic [2:0]  mode;
    logic [7:0]  exp;
  } vec_t;

  vec_t va[12];
  vec_t vb[12];
  int   na;
  int   nb;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic vld, input logic [15:0] ins, input logic [2:0] mode);
    if (sel) begin
      if_b.In_Valid = vld;
      if_b.Inputs   = ins;
      if_b.Mode     = mode;
    end else begin
      if_a.In_Valid = vld;
      if_a.Inputs   = ins[11:0];
      if_a.Mode     = mode;
    end
  endtask

  function automatic logic get_ov(input bit sel);
    return sel ? if_b.Out_Valid : if_a.Out_Valid;
  endfunction

  function automatic logic [7:0] get_res(input bit sel);
    return sel ? if_b.Result : {4'h0, if_a.Result};
  endfunction

  // Back-to-back stream with no backpressure: item c appears two edges
  // after it is driven, so after each edge the output holds item c-1.
  task automatic stream(input bit sel, input int n);
    vec_t v;
    for (int c = 0; c <= n; c++) begin
      if (c < n) begin
        v = sel ? vb[c] : va[c];
        drive(sel, 1'b1, v.ins, v.mode);
      end else begin
        drive(sel, 1'b0, 16'h0, MODE_AND);
      end
      tick();
      if (c >= 1) begin
        v = sel ? vb[c-1] : va[c-1];
        check(sel ? "stream_b_valid" : "stream_a_valid", {15'h0, get_ov(sel)}, 16'h1);
        check(sel ? "stream_b_result" : "stream_a_result", {8'h0, get_res(sel)}, {8'h0, v.exp});
      end
    end
    tick();
    check(sel ? "stream_b_empty" : "stream_a_empty", {15'h0, get_ov(sel)}, 16'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  sent;
    int  recv;
    int  cyc;
    bit  saw_low;
    bit  stall_prev;
    bit  acc;
    logic [3:0] held;

    // {ins = {C,B,A}, mode, expected}
    va[0] = '{16'h0FAC, MODE_NAND, 8'h7};
    va[1] = '{16'h0421, MODE_XOR,  8'h7};
    va[2] = '{16'h0421, MODE_XNOR, 8'h8};
    va[3] = '{16'h0000, MODE_NOR,  8'hF};
    va[4] = '{16'h0100, MODE_OR,   8'h1};
    va[5] = '{16'h0FFF, MODE_AND,  8'hF};
    va[6] = '{16'h0FFE, MODE_AND,  8'hE};
    va[7] = '{16'h0FFF, MODE_NAND, 8'h0};
    va[8] = '{16'h0333, MODE_XOR,  8'h3};
    na = 9;
    // {ins = {B,A}, mode, expected}; B is inverted inside dut_b
    vb[0]  = '{16'h0FF0, MODE_AND,  8'hF0};
    vb[1]  = '{16'h0FF0, MODE_NAND, 8'h0F};
    vb[2]  = '{16'h0FF0, MODE_OR,   8'hF0};
    vb[3]  = '{16'h0FF0, MODE_NOR,  8'h0F};
    vb[4]  = '{16'h0FF0, MODE_XOR,  8'h00};
    vb[5]  = '{16'h0FF0, MODE_XNOR, 8'hFF};
    vb[6]  = '{16'h5A3C, MODE_XOR,  8'h99};
    vb[7]  = '{16'h5A3C, MODE_AND,  8'h24};
    vb[8]  = '{16'h5A3C, MODE_OR,   8'hBD};
    vb[9]  = '{16'h5A3C, MODE_NOR,  8'h42};
    vb[10] = '{16'h5A3C, 3'd7,      8'h00};
    nb = 11;

    // Reset held with In_Valid asserted
    rst = 1'b1;
    drive(1'b0, 1'b1, 16'h0FFF, MODE_AND);
    drive(1'b1, 1'b1, 16'hFFFF, MODE_AND);
    if_a.Out_Ready = 1'b1;
    if_b.Out_Ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_out_valid", {15'h0, if_a.Out_Valid}, 16'h0);
      check("rst_result", {12'h0, if_a.Result}, 16'h0);
      check("rst_in_ready", {15'h0, if_a.In_Ready}, 16'h0);
      check("rst_mode_error", {15'h0, if_a.Mode_Error}, 16'h0);
    end
    check("rst_b_out_valid", {15'h0, if_b.Out_Valid}, 16'h0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 16'h0, MODE_AND);
    drive(1'b1, 1'b0, 16'h0, MODE_AND);
    #1;
    check("post_rst_in_ready", {15'h0, if_a.In_Ready}, 16'h1);

    // Two-cycle latency: NAND(C,A,F) = 7
    drive(1'b0, 1'b1, 16'h0FAC, MODE_NAND);
    tick();
    check("lat_cycle1_valid", {15'h0, if_a.Out_Valid}, 16'h0);
    drive(1'b0, 1'b0, 16'h0, MODE_AND);
    tick();
    check("lat_cycle2_valid", {15'h0, if_a.Out_Valid}, 16'h1);
    check("lat_cycle2_result", {12'h0, if_a.Result}, 16'h7);
    tick();
    check("lat_drained", {15'h0, if_a.Out_Valid}, 16'h0);

    // Table-driven streams
    stream(1'b0, na);
    stream(1'b1, nb);
    check("b_mode_error_sticky", {15'h0, if_b.Mode_Error}, 16'h1);

    // Backpressure: Out_Ready low for cycles 3..7, six items in order
    sent = 0; recv = 0; cyc = 0; saw_low = 0; stall_prev = 0; held = '0;
    while (recv < 6 && cyc < 60) begin
      if_a.Out_Ready = !(cyc >= 3 && cyc <= 7);
      if_a.In_Valid  = (sent < 6);
      if_a.Inputs    = {4'hF, 4'hF, 4'(sent + 1)};
      if_a.Mode      = MODE_AND;
      #1;
      if (!if_a.In_Ready) saw_low = 1;
      if (stall_prev) begin
        check("bp_hold_valid", {15'h0, if_a.Out_Valid}, 16'h1);
        check("bp_hold_result", {12'h0, if_a.Result}, {12'h0, held});
      end
      if (if_a.Out_Valid && if_a.Out_Ready) begin
        check("bp_order", {12'h0, if_a.Result}, 16'(recv + 1));
        recv++;
      end
      stall_prev = if_a.Out_Valid && !if_a.Out_Ready;
      held       = if_a.Result;
      acc        = if_a.In_Valid && if_a.In_Ready;
      tick();
      if (acc) sent++;
      cyc++;
    end
    check("bp_received", 16'(recv), 16'd6);
    check("bp_sent", 16'(sent), 16'd6);
    check("bp_in_ready_dropped", {15'h0, saw_low}, 16'h1);
    if_a.Out_Ready = 1'b1;
    drive(1'b0, 1'b0, 16'h0, MODE_AND);

    // Reserved mode followed by a normal item
    #1;
    check("rsv_flag_before", {15'h0, if_a.Mode_Error}, 16'h0);
    drive(1'b0, 1'b1, 16'h0FFF, 3'd6);
    tick();
    check("rsv_flag_set", {15'h0, if_a.Mode_Error}, 16'h1);
    drive(1'b0, 1'b1, 16'h0FFF, MODE_AND);
    tick();
    check("rsv_valid", {15'h0, if_a.Out_Valid}, 16'h1);
    check("rsv_result_zero", {12'h0, if_a.Result}, 16'h0);
    drive(1'b0, 1'b0, 16'h0, MODE_AND);
    tick();
    check("rsv_next_valid", {15'h0, if_a.Out_Valid}, 16'h1);
    check("rsv_next_result", {12'h0, if_a.Result}, 16'hF);
    check("rsv_flag_sticky", {15'h0, if_a.Mode_Error}, 16'h1);
    tick();
    check("rsv_drained", {15'h0, if_a.Out_Valid}, 16'h0);

    // Reset in the middle of a stall with both stages full
    if_a.Out_Ready = 1'b0;
    drive(1'b0, 1'b1, {4'h0, 4'hF, 4'hF, 4'h5}, MODE_AND);
    tick();
    drive(1'b0, 1'b1, {4'h0, 4'hF, 4'hF, 4'h9}, MODE_AND);
    tick();
    drive(1'b0, 1'b0, 16'h0, MODE_AND);
    #1;
    check("mid_stall_valid", {15'h0, if_a.Out_Valid}, 16'h1);
    check("mid_stall_result", {12'h0, if_a.Result}, 16'h5);
    check("mid_stall_in_ready", {15'h0, if_a.In_Ready}, 16'h0);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", {15'h0, if_a.Out_Valid}, 16'h0);
    check("mid_rst_result", {12'h0, if_a.Result}, 16'h0);
    check("mid_rst_in_ready", {15'h0, if_a.In_Ready}, 16'h0);
    check("mid_rst_mode_error", {15'h0, if_a.Mode_Error}, 16'h0);
    rst = 1'b0;
    if_a.Out_Ready = 1'b1;
    drive(1'b0, 1'b1, {4'h0, 4'hF, 4'hF, 4'h3}, MODE_AND);
    #1;
    check("mid_post_in_ready", {15'h0, if_a.In_Ready}, 16'h1);
    tick();
    check("mid_no_stale", {15'h0, if_a.Out_Valid}, 16'h0);
    drive(1'b0, 1'b0, 16'h0, MODE_AND);
    tick();
    check("mid_new_valid", {15'h0, if_a.Out_Valid}, 16'h1);
    check("mid_new_result", {12'h0, if_a.Result}, 16'h3);
    tick();
    check("mid_new_drained", {15'h0, if_a.Out_Valid}, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
